sgd_loss_sched: RTL and testbench



---
 rtl/sgd_loss_sched_pkg.sv | 26 ++
 rtl/sgd_credit_counter.sv | 56 +++++
 rtl/sgd_loss_sched.sv | 188 ++++++++++++++++++
 tb/tb_sgd_loss_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_loss_sched_pkg.sv
// sgd_loss_sched_pkg: shared types and constants for the serial-loss scheduler.
// Holds the FSM state encoding, the credit counter width helper and the
// saturation limit for the loss-stage shift amount.
package sgd_loss_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_EPOCH_END = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam int unsigned DEF_CREDITS = 62;

  // Width needed to hold the values 0..credits inclusive.
  function automatic int unsigned credit_width(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

  localparam int unsigned CREDIT_W = credit_width(DEF_CREDITS);

  // Largest shift the loss stage accepts; decay saturates here.
  localparam logic [4:0] SHIFT_MAX = 5'd31;

endpackage

// File: rtl/sgd_credit_counter.sv
// sgd_credit_counter: credit pool for b-line grants into the loss-stage b FIFO.
// Ports: grant (a b line was accepted, consumes one credit), ret (a FIFO read,
// returns one credit); outputs credits (current level), has_credit, err
// (sticky: a return arrived while the pool was already full).
module sgd_credit_counter
  import sgd_loss_sched_pkg::*;
#(
  parameter int unsigned CREDITS = DEF_CREDITS,
  parameter int unsigned CW      = credit_width(CREDITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          grant,
  input  logic          ret,
  output logic [CW-1:0] credits,
  output logic          has_credit,
  output logic          err
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] credits_d, credits_q;
  logic          err_d, err_q;
  logic          full;
  logic          ret_ok;
  logic          take;

  always_comb begin
    full      = (credits_q == FULL);
    // A return into a full pool is an underflow upstream: flag it and drop it.
    ret_ok    = ret && !full;
    take      = grant && (credits_q != '0);
    credits_d = credits_q;
    err_d     = err_q || (ret && full);
    if (take && !ret_ok) begin
      credits_d = credits_q - CW'(1);
    end else if (!take && ret_ok) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= FULL;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits    = credits_q;
  assign has_credit = (credits_q != '0);
  assign err        = err_q;

endmodule

// File: rtl/sgd_loss_sched.sv
// sgd_loss_sched: sequences the serial-loss stage across epochs.
// Ports: start + config (num_samples, num_epochs, base_shift, decay_interval)
// latched in IDLE; b_req_valid/b_req_ready grant b lines under credits,
// b_wr_en = accepted line; dot_valid returns a credit, loss_valid retires a
// sample; outputs step_size ({27'b0,shift}), epoch_cnt, busy, done, err,
// stall_cycles. Optional stall counter built when SGD_LOSS_SCHED_STALL_CNT_EN
// is defined; otherwise stall_cycles is tied to zero.
module sgd_loss_sched
  import sgd_loss_sched_pkg::*;
#(
  parameter int unsigned CREDITS = 62,
  parameter int unsigned EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic [4:0]         base_shift,
  input  logic [7:0]         decay_interval,
  input  logic               b_req_valid,
  output logic               b_req_ready,
  output logic               b_wr_en,
  input  logic               dot_valid,
  input  logic               loss_valid,
  output logic [31:0]        step_size,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        stall_cycles
);

  localparam int unsigned CW = credit_width(CREDITS);

  state_e               state_d, state_q;
  logic [31:0]          num_samples_d, num_samples_q;
  logic [EPOCH_W-1:0]   num_epochs_d, num_epochs_q;
  logic [7:0]           decay_interval_d, decay_interval_q;
  logic [4:0]           shift_d, shift_q;
  logic [7:0]           decay_cnt_d, decay_cnt_q;
  logic [EPOCH_W-1:0]   epoch_cnt_d, epoch_cnt_q;
  logic [31:0]          issued_d, issued_q;
  logic [31:0]          retired_d, retired_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;

  logic                 grant;
  logic                 retire;
  logic                 has_credit;
  logic [CW-1:0]        credit_level;
  logic                 credit_level_unused;

  sgd_credit_counter #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .grant      (grant),
    .ret        (dot_valid),
    .credits    (credit_level),
    .has_credit (has_credit),
    .err        (err)
  );

  // The level itself is only of interest when probing the design.
  assign credit_level_unused = ^credit_level;

  // Ready is a function of registered state only, so it can never loop back
  // through the dispatcher's valid.
  assign b_req_ready = (state_q == ST_RUN) && has_credit && (issued_q < num_samples_q);
  assign grant       = b_req_valid && b_req_ready;
  assign b_wr_en     = grant;
  assign retire      = loss_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  always_comb begin
    state_d          = state_q;
    num_samples_d    = num_samples_q;
    num_epochs_d     = num_epochs_q;
    decay_interval_d = decay_interval_q;
    shift_d          = shift_q;
    decay_cnt_d      = decay_cnt_q;
    epoch_cnt_d      = epoch_cnt_q;
    issued_d         = grant  ? issued_q + 32'd1  : issued_q;
    retired_d        = retire ? retired_q + 32'd1 : retired_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_samples_d    = num_samples;
          num_epochs_d     = num_epochs;
          decay_interval_d = decay_interval;
          shift_d          = base_shift;
          epoch_cnt_d      = '0;
          decay_cnt_d      = '0;
          issued_d         = '0;
          retired_d        = '0;
          state_d          = ((num_samples == 32'd0) || (num_epochs == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issued_d == num_samples_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (retired_d == num_samples_q) state_d = ST_EPOCH_END;
      end
      ST_EPOCH_END: begin
        epoch_cnt_d = epoch_cnt_q + EPOCH_W'(1);
        // Shift only moves here, so every result of an epoch sees one shift.
        if ((decay_interval_q != 8'd0) && ((decay_cnt_q + 8'd1) == decay_interval_q)) begin
          shift_d     = (shift_q == SHIFT_MAX) ? SHIFT_MAX : shift_q + 5'd1;
          decay_cnt_d = 8'd0;
        end else begin
          decay_cnt_d = decay_cnt_q + 8'd1;
        end
        issued_d  = '0;
        retired_d = '0;
        state_d   = ((epoch_cnt_q + EPOCH_W'(1)) == num_epochs_q) ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_EPOCH_END);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      num_samples_q    <= '0;
      num_epochs_q     <= '0;
      decay_interval_q <= '0;
      shift_q          <= '0;
      decay_cnt_q      <= '0;
      epoch_cnt_q      <= '0;
      issued_q         <= '0;
      retired_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_samples_q    <= num_samples_d;
      num_epochs_q     <= num_epochs_d;
      decay_interval_q <= decay_interval_d;
      shift_q          <= shift_d;
      decay_cnt_q      <= decay_cnt_d;
      epoch_cnt_q      <= epoch_cnt_d;
      issued_q         <= issued_d;
      retired_q        <= retired_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign step_size = {27'b0, shift_q};
  assign epoch_cnt = epoch_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef SGD_LOSS_SCHED_STALL_CNT_EN
  logic [31:0] stall_d, stall_q;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q == ST_RUN) && b_req_valid && !b_req_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sgd_loss_sched.sv
module tb_sgd_loss_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_samples;
  logic [15:0] num_epochs;
  logic [4:0]  base_shift;
  logic [7:0]  decay_interval;
  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_wr_en;
  logic        dot_valid;
  logic        loss_valid;
  logic [31:0] step_size;
  logic [15:0] epoch_cnt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] stall_cycles;

  int vec    = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  sgd_loss_sched #(.CREDITS(62), .EPOCH_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_samples    (num_samples),
    .num_epochs     (num_epochs),
    .base_shift     (base_shift),
    .decay_interval (decay_interval),
    .b_req_valid    (b_req_valid),
    .b_req_ready    (b_req_ready),
    .b_wr_en        (b_wr_en),
    .dot_valid      (dot_valid),
    .loss_valid     (loss_valid),
    .step_size      (step_size),
    .epoch_cnt      (epoch_cnt),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .stall_cycles   (stall_cycles)
  );

  // Move to the drive point just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; b_req_valid = 0; dot_valid = 0; loss_valid = 0;
    num_samples = 0; num_epochs = 0; base_shift = 0; decay_interval = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    nxt();
    nxt();
    rst = 0;
  endtask

  // Config is zeroed right after the pulse so the run depends on latched values.
  task automatic pulse_start(input logic [31:0] ns, input logic [15:0] ne,
                             input logic [4:0] bs, input logic [7:0] di);
    start = 1; num_samples = ns; num_epochs = ne; base_shift = bs; decay_interval = di;
    nxt();
    start = 0; num_samples = 0; num_epochs = 0; base_shift = 0; decay_interval = 0;
  endtask

  // One epoch: grant n lines, then return n credits and retire n samples.
  // Returns at the cycle after the last loss_valid.
  task automatic run_epoch(input int n, output logic [31:0] step_seen, output int grants);
    grants = 0;
    step_seen = 32'hFFFF_FFFF;
    b_req_valid = 1;
    for (int i = 0; i < 40 && grants < n; i++) begin
      @(negedge clk);
      if (b_wr_en === 1'b1) begin
        if (grants == 0) step_seen = step_size;
        grants++;
      end
      nxt();
    end
    b_req_valid = 0;
    dot_valid = 1; loss_valid = 1;
    repeat (n) nxt();
    dot_valid = 0; loss_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    b_req_valid = 1;
    @(negedge clk);
    vec++; if (b_req_ready !== 1'b0) begin miscmp++; $display("FAIL reset_ready: got %0d want 0", b_req_ready); end
    vec++; if (b_wr_en !== 1'b0) begin miscmp++; $display("FAIL reset_wr_en: got %0d want 0", b_wr_en); end
    vec++; if (step_size !== 32'd0) begin miscmp++; $display("FAIL reset_step: got %0d want 0", step_size); end
    vec++; if (epoch_cnt !== 16'd0) begin miscmp++; $display("FAIL reset_epoch: got %0d want 0", epoch_cnt); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy: got %0d want 0", busy); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL reset_done: got %0d want 0", done); end
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL reset_err: got %0d want 0", err); end
    vec++; if (stall_cycles !== 32'd0) begin miscmp++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    nxt();
    b_req_valid = 0;
  endtask

  task automatic test_credit_backpressure();
    int g;
    int exp_stall;
    do_reset();
    pulse_start(32'd100, 16'd1, 5'd0, 8'd0);
    b_req_valid = 1;
    g = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL bp_busy_after_start: got %0d want 1", busy); end
      end
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    b_req_valid = 0;
    @(negedge clk);
    vec++; if (g != 62) begin miscmp++; $display("FAIL bp_grant_count: got %0d want 62", g); end
    vec++; if (b_req_ready !== 1'b0) begin miscmp++; $display("FAIL bp_ready_low: got %0d want 0", b_req_ready); end
`ifdef SGD_LOSS_SCHED_STALL_CNT_EN
    exp_stall = 18;
`else
    exp_stall = 0;
`endif
    vec++; if (stall_cycles !== 32'(exp_stall)) begin miscmp++; $display("FAIL bp_stall_cycles: got %0d want %0d", stall_cycles, exp_stall); end
    nxt();
    g = 0;
    b_req_valid = 1;
    for (int i = 0; i < 11; i++) begin
      dot_valid = (i == 0);
      @(negedge clk);
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    dot_valid = 0; b_req_valid = 0;
    vec++; if (g != 1) begin miscmp++; $display("FAIL bp_one_return_one_grant: got %0d want 1", g); end
  endtask

  task automatic test_back_to_back();
    int g;
    do_reset();
    pulse_start(32'd1000, 16'd1, 5'd0, 8'd0);
    b_req_valid = 1;
    @(negedge clk);
    vec++; if (b_wr_en !== 1'b1) begin miscmp++; $display("FAIL b2b_first_grant: got %0d want 1", b_wr_en); end
    nxt();
    g = 0;
    dot_valid = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    dot_valid = 0;
    vec++; if (g != 200) begin miscmp++; $display("FAIL b2b_continuous: got %0d want 200", g); end
    g = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    b_req_valid = 0;
    vec++; if (g != 61) begin miscmp++; $display("FAIL b2b_credits_constant: got %0d want 61", g); end
    @(negedge clk);
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL b2b_err: got %0d want 0", err); end
    nxt();
  endtask

  task automatic test_decay();
    int          exp_s [5] = '{3, 3, 4, 4, 5};
    logic [31:0] s;
    int          g;
    do_reset();
    pulse_start(32'd4, 16'd5, 5'd3, 8'd2);
    for (int e = 0; e < 5; e++) begin
      run_epoch(4, s, g);
      vec++; if (g != 4) begin miscmp++; $display("FAIL decay_grants_e%0d: got %0d want 4", e, g); end
      vec++; if (s !== 32'(exp_s[e])) begin miscmp++; $display("FAIL decay_step_e%0d: got %0d want %0d", e, s, exp_s[e]); end
    end
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL decay_done_early: got %0d want 0", done); end
    nxt();
    @(negedge clk);
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL decay_done_t2: got %0d want 1", done); end
    vec++; if (epoch_cnt !== 16'd5) begin miscmp++; $display("FAIL decay_epoch_cnt: got %0d want 5", epoch_cnt); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL decay_busy_done: got %0d want 0", busy); end
    nxt();
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL decay_done_pulse: got %0d want 0", done); end
    vec++; if (step_size !== 32'd5) begin miscmp++; $display("FAIL decay_step_hold: got %0d want 5", step_size); end
    vec++; if (epoch_cnt !== 16'd5) begin miscmp++; $display("FAIL decay_epoch_hold: got %0d want 5", epoch_cnt); end
    nxt();
  endtask

  task automatic test_saturation();
    int          exp_s [4] = '{30, 31, 31, 31};
    logic [31:0] s;
    int          g;
    do_reset();
    pulse_start(32'd1, 16'd4, 5'd30, 8'd1);
    for (int e = 0; e < 4; e++) begin
      run_epoch(1, s, g);
      vec++; if (s !== 32'(exp_s[e])) begin miscmp++; $display("FAIL sat_step_e%0d: got %0d want %0d", e, s, exp_s[e]); end
    end
    nxt();
    @(negedge clk);
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL sat_done: got %0d want 1", done); end
    vec++; if (epoch_cnt !== 16'd4) begin miscmp++; $display("FAIL sat_epoch_cnt: got %0d want 4", epoch_cnt); end
    vec++; if (step_size !== 32'd31) begin miscmp++; $display("FAIL sat_step_final: got %0d want 31", step_size); end
    nxt();
  endtask

  task automatic test_degenerate();
    do_reset();
    pulse_start(32'd0, 16'd3, 5'd7, 8'd0);
    b_req_valid = 1;
    @(negedge clk);
    vec++; if (done !== 1'b1) begin miscmp++; $display("FAIL degen_done: got %0d want 1", done); end
    vec++; if (b_wr_en !== 1'b0) begin miscmp++; $display("FAIL degen_no_grant: got %0d want 0", b_wr_en); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL degen_busy: got %0d want 0", busy); end
    vec++; if (step_size !== 32'd7) begin miscmp++; $display("FAIL degen_step: got %0d want 7", step_size); end
    nxt();
    @(negedge clk);
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL degen_done_pulse: got %0d want 0", done); end
    nxt();
    b_req_valid = 0;
    dot_valid = 1;
    nxt();
    dot_valid = 0;
    @(negedge clk);
    vec++; if (err !== 1'b1) begin miscmp++; $display("FAIL err_set_idle: got %0d want 1", err); end
    repeat (5) nxt();
    @(negedge clk);
    vec++; if (err !== 1'b1) begin miscmp++; $display("FAIL err_sticky: got %0d want 1", err); end
    do_reset();
    @(negedge clk);
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL err_clear_rst: got %0d want 0", err); end
    nxt();
  endtask

  task automatic test_reset_mid_drain();
    int g;
    do_reset();
    pulse_start(32'd3, 16'd2, 5'd2, 8'd0);
    b_req_valid = 1;
    g = 0;
    for (int i = 0; i < 10 && g < 3; i++) begin
      @(negedge clk);
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    b_req_valid = 0;
    vec++; if (g != 3) begin miscmp++; $display("FAIL rmd_grants: got %0d want 3", g); end
    // Now in DRAIN: retire one sample and try to restart with other config.
    loss_valid = 1;
    start = 1; num_samples = 32'd50; num_epochs = 16'd1; base_shift = 5'd9;
    nxt();
    loss_valid = 0;
    start = 0; num_samples = 0; num_epochs = 0; base_shift = 0;
    @(negedge clk);
    vec++; if (step_size !== 32'd2) begin miscmp++; $display("FAIL rmd_start_ignored_step: got %0d want 2", step_size); end
    vec++; if (busy !== 1'b1) begin miscmp++; $display("FAIL rmd_busy_drain: got %0d want 1", busy); end
    nxt();
    rst = 1;
    nxt();
    rst = 0;
    b_req_valid = 1;
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL rmd_busy: got %0d want 0", busy); end
    vec++; if (b_req_ready !== 1'b0) begin miscmp++; $display("FAIL rmd_ready: got %0d want 0", b_req_ready); end
    vec++; if (step_size !== 32'd0) begin miscmp++; $display("FAIL rmd_step: got %0d want 0", step_size); end
    vec++; if (epoch_cnt !== 16'd0) begin miscmp++; $display("FAIL rmd_epoch: got %0d want 0", epoch_cnt); end
    vec++; if (done !== 1'b0) begin miscmp++; $display("FAIL rmd_done: got %0d want 0", done); end
    vec++; if (err !== 1'b0) begin miscmp++; $display("FAIL rmd_err: got %0d want 0", err); end
    nxt();
    b_req_valid = 0;
    // A full pool of 62 credits must be available again.
    pulse_start(32'd100, 16'd1, 5'd0, 8'd0);
    b_req_valid = 1;
    g = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (b_wr_en === 1'b1) g++;
      nxt();
    end
    b_req_valid = 0;
    vec++; if (g != 62) begin miscmp++; $display("FAIL rmd_credits_restored: got %0d want 62", g); end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_credit_backpressure();
    test_back_to_back();
    test_decay();
    test_saturation();
    test_degenerate();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
